shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter SHIFTER_OPERAND_WIDTH, default 12, shifter operand field width.
REQ-003 SHALL have parameter STEP, default 4, maximum bit positions shifted/rotated per cycle; legal range 1..16.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous abort of any in-flight operation.
REQ-007 in_valid  input  1  request presented.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 imm  input  1  immediate operand mode.
REQ-010 for_mem  input  1  memory-offset mode.
REQ-011 shifter_operand  input  SHIFTER_OPERAND_WIDTH  operand-2 encoding.
REQ-012 Val_Rm  input  WORD_WIDTH  register operand value.
REQ-013 out_valid  output  1  Val2_out holds a completed result.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 Val2_out  output  WORD_WIDTH  generated operand 2.
REQ-016 busy  output  1  high whenever state is not IDLE; pipeline stall hint.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both high at a rising edge.
REQ-019 On acceptance SHALL register operands, mode, shift type and amount; later input changes SHALL NOT affect the operation.
REQ-020 Mode priority: for_mem over imm over register shift.
REQ-021 for_mem: result = zero-extended shifter_operand; IDLE -> DONE directly.
REQ-022 imm: working value = zero-extended shifter_operand[7:0]; rotate right by amount = 2*shifter_operand[11:8] (0..30).
REQ-023 register: working value = Val_Rm; amount = shifter_operand[11:7] (0..31); type shifter_operand[6:5]: 00 LSL, 01 LSR (zero fill), 10 ASR (sign-bit fill), 11 ROR.
REQ-024 amount 0 in imm or register mode: result = working value unchanged; IDLE -> DONE directly.
REQ-025 amount > 0: IDLE -> SHIFT; each SHIFT cycle applies min(STEP, remaining) positions and decrements remaining by the same; SHIFT -> DONE on the cycle remaining reaches 0.
REQ-026 Latency: out_valid SHALL rise exactly 1 + ceil(amount/STEP) cycles after the acceptance edge (1 cycle for for_mem or amount 0).
REQ-027 Multi-step result SHALL be bit-identical to a single shift by the full amount (ASR keeps the original sign bit throughout).
REQ-028 In DONE: out_valid = 1; Val2_out and out_valid SHALL hold stable while out_ready = 0; DONE -> IDLE on out_ready = 1.
REQ-029 No back-to-back acceptance: a new request is accepted no earlier than the cycle after DONE exits.
REQ-030 flush = 1 at an edge SHALL force IDLE from any state, drop any result, clear out_valid; flush has priority over acceptance and out_ready.
REQ-031 Val2_out outside DONE SHALL retain its last value (not required to be meaningful).

Reset
REQ-032 rst high SHALL immediately force state IDLE, out_valid = 0, busy = 0, in_ready = 1, Val2_out = 0, remaining count = 0, independent of clk.
REQ-033 rst asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse after release until a new request completes.

Verification
REQ-034 imm=1, shifter_operand=0x4FF, STEP=4 -> Val2_out=0xFF000000, out_valid 3 cycles after accept.
REQ-035 for_mem=1, shifter_operand=0xABC -> Val2_out=0x00000ABC, out_valid 1 cycle after accept, busy 1 for exactly that cycle.
REQ-036 Val_Rm=0x80000000, shifter_operand=0x240 (ASR 4) -> Val2_out=0xF8000000 after 1 SHIFT cycle; Val_Rm=0x00000001, shifter_operand=0xFE0 (ROR 31) -> 0x00000002 after 8 SHIFT cycles.
REQ-037 Result in DONE with out_ready held low 5 cycles -> out_valid and Val2_out stable, in_ready 0; out_ready high -> IDLE next cycle, in_ready 1.
REQ-038 flush pulsed during SHIFT (ROR 31 case) -> IDLE next cycle, out_valid never asserted; repeat with async rst mid-cycle -> outputs cleared before next edge.
REQ-039 Sweep all types, amounts 0..31 and STEP in {1,4,16} with random Val_Rm -> result matches single-step reference shift and latency matches REQ-026.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Request/response bundle for shift_sequencer. The requester (pipeline
//   decode stage) uses the master modport and the sequencer uses the slave
//   modport. clk and rst are not carried here.
//
//   flush            master->slave  synchronous abort of any in-flight op
//   in_valid         master->slave  request presented
//   in_ready         slave->master  sequencer can accept a request
//   imm              master->slave  immediate operand mode
//   for_mem          master->slave  memory-offset mode
//   shifter_operand  master->slave  operand-2 encoding
//   Val_Rm           master->slave  register operand value
//   out_valid        slave->master  Val2_out holds a completed result
//   out_ready        master->slave  consumer accepts result
//   Val2_out         slave->master  generated operand 2
//   busy             slave->master  sequencer not idle (stall hint)
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int WORD_WIDTH            = 32,
    parameter int SHIFTER_OPERAND_WIDTH = 12
);
    logic                             flush;
    logic                             in_valid;
    logic                             in_ready;
    logic                             imm;
    logic                             for_mem;
    logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand;
    logic [WORD_WIDTH-1:0]            Val_Rm;
    logic                             out_valid;
    logic                             out_ready;
    logic [WORD_WIDTH-1:0]            Val2_out;
    logic                             busy;

    modport master (
        output flush, in_valid, imm, for_mem, shifter_operand, Val_Rm, out_ready,
        input  in_ready, out_valid, Val2_out, busy
    );

    modport slave (
        input  flush, in_valid, imm, for_mem, shifter_operand, Val_Rm, out_ready,
        output in_ready, out_valid, Val2_out, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Generates ARM-style operand 2 with a small iterative barrel shifter that
//   moves at most STEP bit positions per cycle. Three modes, in priority:
//     for_mem  : zero-extended shifter_operand, no shift
//     imm      : zero-extended imm8 rotated right by 2*rot4
//     register : Val_Rm shifted by shift_imm5 using LSL/LSR/ASR/ROR
//   A request is accepted in IDLE, walks through SHIFT for ceil(amount/STEP)
//   cycles (skipped when the amount is zero) and is held in DONE until the
//   consumer raises out_ready.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : shift_sequencer_if.slave (request, response, flush, busy)
//
//   The interface instance must be built with the same WORD_WIDTH and
//   SHIFTER_OPERAND_WIDTH as this module; SHIFTER_OPERAND_WIDTH >= 12 and
//   STEP in 1..16.
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WORD_WIDTH            = 32,
    parameter int SHIFTER_OPERAND_WIDTH = 12,
    parameter int STEP                  = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encoding matches shifter_operand[6:5].
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    localparam int              AMT_W    = 5;
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_t                r_state;
    state_t                w_next_state;

    logic [WORD_WIDTH-1:0] r_work;
    shift_t                r_type;
    logic [AMT_W-1:0]      r_remaining;
    logic [WORD_WIDTH-1:0] r_val2;

    logic [WORD_WIDTH-1:0] w_in_work;
    logic [AMT_W-1:0]      w_in_amount;
    shift_t                w_in_type;

    logic [AMT_W-1:0]      w_step;
    logic [WORD_WIDTH-1:0] w_shifted;
    logic                  w_last_step;

    // ------------------------------------------------------------------
    // Request decode: working value, shift type and total amount.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_in_work   = '0;
        w_in_amount = '0;
        w_in_type   = SH_ROR;
        if (bus.for_mem) begin
            w_in_work = WORD_WIDTH'(bus.shifter_operand);
        end else if (bus.imm) begin
            w_in_work   = WORD_WIDTH'(bus.shifter_operand[7:0]);
            w_in_amount = {bus.shifter_operand[11:8], 1'b0};
        end else begin
            w_in_work   = bus.Val_Rm;
            w_in_amount = bus.shifter_operand[11:7];
            w_in_type   = shift_t'(bus.shifter_operand[6:5]);
        end
    end

    // ------------------------------------------------------------------
    // One partial shift per cycle. Chaining partial shifts gives the same
    // result as a single full shift: ASR re-reads the preserved sign bit
    // each step and ROR is closed under composition.
    // ------------------------------------------------------------------
    assign w_step      = (r_remaining > STEP_AMT) ? STEP_AMT : r_remaining;
    assign w_last_step = (r_remaining == w_step);

    always_comb begin
        w_shifted = r_work;
        case (r_type)
            SH_LSL:  w_shifted = r_work << w_step;
            SH_LSR:  w_shifted = r_work >> w_step;
            SH_ASR:  w_shifted = $signed(r_work) >>> w_step;
            default: w_shifted = (r_work >> w_step)
                               | (r_work << (WORD_WIDTH - int'(w_step)));
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (bus.flush) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = (w_in_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_step) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
    end

    assign bus.Val2_out = r_val2;

    // ------------------------------------------------------------------
    // Datapath. r_val2 only changes on the way into DONE, so Val2_out keeps
    // its last result while idle or shifting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work      <= '0;
            r_type      <= SH_LSL;
            r_remaining <= '0;
            r_val2      <= '0;
        end else if (bus.flush) begin
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_work      <= w_in_work;
                        r_type      <= w_in_type;
                        r_remaining <= w_in_amount;
                        if (w_in_amount == '0) begin
                            r_val2 <= w_in_work;
                        end
                    end
                end
                SHIFT: begin
                    r_work      <= w_shifted;
                    r_remaining <= r_remaining - w_step;
                    if (w_last_step) begin
                        r_val2 <= w_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
